// File: rtl/fifo_level.sv
// rtl/fifo_level.sv - parametrised FIFO with occupancy level, threshold flags and sticky errors
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module fifo_level #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 15,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wren,
    input  logic [WIDTH-1:0]           i_datain,
    input  logic                       i_rden,
    input  logic                       i_clr_err,
    output logic [WIDTH-1:0]           o_dataout,
    output logic                       o_valid,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_almost_full,
    output logic                       o_almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_overflow,
    output logic                       o_underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_LVL   = LW'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrptr;
    logic [PW-1:0]    rdptr;
    logic             acc_wr;
    logic             acc_rd;
    logic [LW-1:0]    level_next;

    // A full FIFO still takes a write when the same-cycle read frees a slot.
    assign acc_wr = i_wren & (~o_full | i_rden);
    assign acc_rd = i_rden & ~o_empty;

    always_comb begin
        level_next = o_level;
        if (acc_wr && !acc_rd) begin
            level_next = o_level + LW'(1);
        end else if (acc_rd && !acc_wr) begin
            level_next = o_level - LW'(1);
        end
    end

    // Depth need not be a power of two, so wrap by explicit compare.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (acc_wr) begin
            mem[wrptr] <= i_datain;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wrptr          <= '0;
            rdptr          <= '0;
            o_level        <= '0;
            o_full         <= 1'b0;
            o_empty        <= 1'b1;
            o_almost_full  <= 1'b0;
            o_almost_empty <= 1'b1;
            o_overflow     <= 1'b0;
            o_underflow    <= 1'b0;
        end else begin
            if (acc_wr) begin
                wrptr <= ptr_inc(wrptr);
            end
            if (acc_rd) begin
                rdptr <= ptr_inc(rdptr);
            end
            // Flags come from the next level so they move on the same edge as o_level.
            o_level        <= level_next;
            o_full         <= (level_next == FULL_LVL);
            o_empty        <= (level_next == '0);
            o_almost_full  <= (level_next >= AF_LVL);
            o_almost_empty <= (level_next <= AE_LVL);
            if (i_wren && !acc_wr) begin
                o_overflow <= 1'b1;
            end else if (i_clr_err) begin
                o_overflow <= 1'b0;
            end
            if (i_rden && o_empty) begin
                o_underflow <= 1'b1;
            end else if (i_clr_err) begin
                o_underflow <= 1'b0;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    assign o_dataout = mem[rdptr];
    assign o_valid   = ~o_empty;
`else
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_dataout <= '0;
            o_valid   <= 1'b0;
        end else begin
            o_valid <= acc_rd;
            if (acc_rd) begin
                o_dataout <= mem[rdptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_level.sv
// tb/tb_fifo_level.sv - randomized scoreboard bench for fifo_level against a queue model
module tb_fifo_level;

    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_wren = 1'b0;
    logic [WIDTH-1:0] i_datain = '0;
    logic             i_rden = 1'b0;
    logic             i_clr_err = 1'b0;
    logic [WIDTH-1:0] o_dataout;
    logic             o_valid;
    logic             o_full;
    logic             o_empty;
    logic             o_almost_full;
    logic             o_almost_empty;
    logic [LW-1:0]    o_level;
    logic             o_overflow;
    logic             o_underflow;

    fifo_level #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_wren(i_wren), .i_datain(i_datain),
        .i_rden(i_rden), .i_clr_err(i_clr_err), .o_dataout(o_dataout),
        .o_valid(o_valid), .o_full(o_full), .o_empty(o_empty),
        .o_almost_full(o_almost_full), .o_almost_empty(o_almost_empty),
        .o_level(o_level), .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;

    int               total = 0;
    int               bad = 0;
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] exp_q[$];
    bit               m_ovf = 0;
    bit               m_uf = 0;
    bit               m_valid = 0;
    logic [WIDTH-1:0] m_dout = '0;
    bit               mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model applies the FIFO rules to its queue after the edge.
    task automatic step(input bit wr, input bit rd, input logic [WIDTH-1:0] d, input bit clr);
        int sz;
        bit aw;
        bit ar;
        i_wren = wr;
        i_rden = rd;
        i_datain = d;
        i_clr_err = clr;
        @(posedge i_clk);
        #1;
        sz = mq.size();
        aw = wr && (sz < DEPTH || rd);
        ar = rd && (sz > 0);
        m_valid = ar;
        if (ar) exp_q.push_back(mq.pop_front());
        if (aw) mq.push_back(d);
        if (wr && !aw) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (rd && sz == 0) m_uf = 1;
        else if (clr) m_uf = 0;
        i_wren = 0;
        i_rden = 0;
        i_clr_err = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_ovf = 0;
        m_uf = 0;
        m_valid = 0;
        m_dout = '0;
    endtask

    always @(negedge i_clk) begin
        if (mon_en && !i_rst) begin
            chk("level", 32'(o_level), mq.size());
            chk("empty", 32'(o_empty), 32'(mq.size() == 0));
            chk("full", 32'(o_full), 32'(mq.size() == DEPTH));
            chk("almost_full", 32'(o_almost_full), 32'(mq.size() >= AF));
            chk("almost_empty", 32'(o_almost_empty), 32'(mq.size() <= AE));
            chk("overflow", 32'(o_overflow), 32'(m_ovf));
            chk("underflow", 32'(o_underflow), 32'(m_uf));
`ifdef FIFO_FWFT_EN
            chk("valid", 32'(o_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) chk("head", 32'(o_dataout), 32'(mq[0]));
            exp_q.delete();
`else
            chk("valid", 32'(o_valid), 32'(m_valid));
            if (o_valid) begin
                chk("read_pending", exp_q.size(), 1);
                if (exp_q.size() > 0) m_dout = exp_q.pop_front();
                chk("dataout", 32'(o_dataout), 32'(m_dout));
            end else begin
                chk("dataout_hold", 32'(o_dataout), 32'(m_dout));
            end
`endif
        end
    end

    initial begin
        int p_wr;
        int p_rd;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1 i_rst = 0;
        mon_en = 1;

        // two writes then two reads
        step(1, 0, 8'h11, 0);
        step(1, 0, 8'h22, 0);
        chk("two_writes_level", 32'(o_level), 2);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // fill, overflow, drain
        for (int i = 1; i <= 5; i++) step(1, 0, 8'(i), 0);
        step(1, 0, 8'hFF, 0);
        chk("overflow_set", 32'(o_overflow), 1);
        chk("overflow_level", 32'(o_level), 5);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 1);

        // pointer wrap
        for (int i = 0; i < 3; i++) step(1, 0, 8'(i + 8'h30), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hA0 + i), 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);

        // simultaneous read/write at full and at empty
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h60 + i), 0);
        step(1, 1, 8'h77, 0);
        chk("full_rw_level", 32'(o_level), 5);
        chk("full_rw_no_ovf", 32'(o_overflow), 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        step(1, 1, 8'h88, 0);
        chk("empty_rw_underflow", 32'(o_underflow), 1);
        chk("empty_rw_level", 32'(o_level), 1);
        step(0, 1, 0, 1);

        // error clear, and set winning over clear
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hC0 + i), 0);
        step(1, 0, 8'hEE, 0);
        step(0, 0, 0, 1);
        chk("ovf_cleared", 32'(o_overflow), 0);
        step(1, 0, 8'hEF, 1);
        chk("ovf_set_wins", 32'(o_overflow), 1);

        // async reset mid-drain at level 3
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("pre_reset_level", 32'(o_level), 3);
        #1 i_rst = 1;
        #1;
        chk("async_rst_level", 32'(o_level), 0);
        chk("async_rst_empty", 32'(o_empty), 1);
        chk("async_rst_valid", 32'(o_valid), 0);
        model_reset();
        @(posedge i_clk);
        #1 i_rst = 0;

        // randomized traffic with shifting write/read bias
        for (int blk = 0; blk < 18; blk++) begin
            p_wr = (blk % 3 == 0) ? 80 : (blk % 3 == 1) ? 20 : 50;
            p_rd = 100 - p_wr;
            for (int i = 0; i < 100; i++) begin
                step($urandom_range(0, 99) < p_wr, $urandom_range(0, 99) < p_rd,
                     8'($urandom), $urandom_range(0, 31) == 0);
            end
        end

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("no_lost_reads", exp_q.size(), 0);
        @(negedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
